// File: rtl/exe_mem_reg_pkg.sv
// Shared widths, funct3 encodings and the control bundle for the EXE/MEM register.
package exe_mem_reg_pkg;

  localparam int DATA_BITS   = 32;
  localparam int ADDR_BITS   = 32;
  localparam int REG_ADDR    = 5;
  localparam int FUNCT3_BITS = 3;
  localparam int MA_CNT_BITS = 8;

  localparam logic [FUNCT3_BITS-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_BITS-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_BITS-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_BITS-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_BITS-1:0] F3_HU = 3'b101;

  typedef struct packed {
    logic rd_src;
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic reg_write;
  } exemem_ctrl_t;

endpackage

// File: rtl/exe_mem_reg_align_chk.sv
// Combinational natural-alignment check for load/store effective addresses.
import exe_mem_reg_pkg::*;

module mem_align_chk (
  input  logic [FUNCT3_BITS-1:0] funct3,
  input  logic [1:0]             addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  output logic                   misalign
);

  // Only the size bits matter; the unsigned bit (funct3[2]) does not affect alignment.
  always_comb begin
    misalign = 1'b0;
    if (mem_read || mem_write) begin
      unique case (funct3[1:0])
        2'b01:   misalign = addr[0];
        2'b10:   misalign = (addr != 2'b00);
        default: misalign = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register: captures execute results, forms pc_to_reg,
// suppresses side effects of misaligned accesses and counts them.
import exe_mem_reg_pkg::*;

module exe_mem_reg #(
  parameter int DATA_BITS   = exe_mem_reg_pkg::DATA_BITS,
  parameter int ADDR_BITS   = exe_mem_reg_pkg::ADDR_BITS,
  parameter int REG_ADDR    = exe_mem_reg_pkg::REG_ADDR,
  parameter int FUNCT3_BITS = exe_mem_reg_pkg::FUNCT3_BITS,
  parameter int MA_CNT_BITS = exe_mem_reg_pkg::MA_CNT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   IDEXE_RDSrc,
  input  logic                   IDEXE_PCtoRegSrc,
  input  logic                   IDEXE_MemtoReg,
  input  logic                   IDEXE_MemWrite,
  input  logic                   IDEXE_MemRead,
  input  logic                   IDEXE_RegWrite,
  input  logic [ADDR_BITS-1:0]   IDEXE_pc,
  input  logic [DATA_BITS-1:0]   IDEXE_imm,
  input  logic [REG_ADDR-1:0]    IDEXE_rd_addr,
  input  logic [FUNCT3_BITS-1:0] IDEXE_funct3,
  input  logic [DATA_BITS-1:0]   ALU_out,
  input  logic [DATA_BITS-1:0]   rs2_fwd_data,
  output logic                   EXEMEM_RDSrc,
  output logic                   EXEMEM_MemtoReg,
  output logic                   EXEMEM_MemWrite,
  output logic                   EXEMEM_MemRead,
  output logic                   EXEMEM_RegWrite,
  output logic [ADDR_BITS-1:0]   EXEMEM_pc_to_reg,
  output logic [DATA_BITS-1:0]   EXEMEM_ALU_out,
  output logic [DATA_BITS-1:0]   EXEMEM_rs2_data,
  output logic [REG_ADDR-1:0]    EXEMEM_rd_addr,
  output logic [FUNCT3_BITS-1:0] EXEMEM_funct3,
  output logic                   EXEMEM_load_pending,
  output logic                   EXEMEM_misalign,
  output logic [MA_CNT_BITS-1:0] ma_count
);

  exemem_ctrl_t           ctrl_d, ctrl_q;
  logic [ADDR_BITS-1:0]   pc_to_reg_d, pc_to_reg_q;
  logic [DATA_BITS-1:0]   alu_out_d, alu_out_q;
  logic [DATA_BITS-1:0]   rs2_data_d, rs2_data_q;
  logic [REG_ADDR-1:0]    rd_addr_d, rd_addr_q;
  logic [FUNCT3_BITS-1:0] funct3_d, funct3_q;
  logic                   misalign_d, misalign_q;
  logic [MA_CNT_BITS-1:0] ma_count_d, ma_count_q;

  logic                   misalign_now;
  logic [ADDR_BITS-1:0]   pc_to_reg_now;

  mem_align_chk u_align_chk (
    .funct3    (IDEXE_funct3),
    .addr      (ALU_out[1:0]),
    .mem_read  (IDEXE_MemRead),
    .mem_write (IDEXE_MemWrite),
    .misalign  (misalign_now)
  );

  // Wrap-around on overflow is intentional (modulo 2^ADDR_BITS).
  assign pc_to_reg_now = IDEXE_PCtoRegSrc ? (IDEXE_pc + ADDR_BITS'(IDEXE_imm))
                                          : (IDEXE_pc + ADDR_BITS'(4));

  always_comb begin
    ctrl_d      = ctrl_q;
    pc_to_reg_d = pc_to_reg_q;
    alu_out_d   = alu_out_q;
    rs2_data_d  = rs2_data_q;
    rd_addr_d   = rd_addr_q;
    funct3_d    = funct3_q;
    misalign_d  = misalign_q;
    ma_count_d  = ma_count_q;
    if (flush) begin
      ctrl_d      = '0;
      pc_to_reg_d = '0;
      alu_out_d   = '0;
      rs2_data_d  = '0;
      rd_addr_d   = '0;
      funct3_d    = '0;
      misalign_d  = 1'b0;
    end else if (!stall) begin
      ctrl_d.rd_src     = IDEXE_RDSrc;
      ctrl_d.mem_to_reg = IDEXE_MemtoReg;
      ctrl_d.mem_write  = IDEXE_MemWrite & ~misalign_now;
      ctrl_d.mem_read   = IDEXE_MemRead  & ~misalign_now;
      ctrl_d.reg_write  = IDEXE_RegWrite & ~misalign_now;
      pc_to_reg_d       = pc_to_reg_now;
      alu_out_d         = ALU_out;
      rs2_data_d        = rs2_fwd_data;
      rd_addr_d         = IDEXE_rd_addr;
      funct3_d          = IDEXE_funct3;
      misalign_d        = misalign_now;
      if (misalign_now && (ma_count_q != {MA_CNT_BITS{1'b1}}))
        ma_count_d = ma_count_q + MA_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= '0;
      pc_to_reg_q <= '0;
      alu_out_q   <= '0;
      rs2_data_q  <= '0;
      rd_addr_q   <= '0;
      funct3_q    <= '0;
      misalign_q  <= 1'b0;
      ma_count_q  <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      pc_to_reg_q <= pc_to_reg_d;
      alu_out_q   <= alu_out_d;
      rs2_data_q  <= rs2_data_d;
      rd_addr_q   <= rd_addr_d;
      funct3_q    <= funct3_d;
      misalign_q  <= misalign_d;
      ma_count_q  <= ma_count_d;
    end
  end

  assign EXEMEM_RDSrc        = ctrl_q.rd_src;
  assign EXEMEM_MemtoReg     = ctrl_q.mem_to_reg;
  assign EXEMEM_MemWrite     = ctrl_q.mem_write;
  assign EXEMEM_MemRead      = ctrl_q.mem_read;
  assign EXEMEM_RegWrite     = ctrl_q.reg_write;
  assign EXEMEM_pc_to_reg    = pc_to_reg_q;
  assign EXEMEM_ALU_out      = alu_out_q;
  assign EXEMEM_rs2_data     = rs2_data_q;
  assign EXEMEM_rd_addr      = rd_addr_q;
  assign EXEMEM_funct3       = funct3_q;
  assign EXEMEM_misalign     = misalign_q;
  assign EXEMEM_load_pending = ctrl_q.mem_read;
  assign ma_count            = ma_count_q;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed bench for exe_mem_reg: reset, load/store capture, misalign counting,
// stall/flush and pc_to_reg arithmetic.
module tb_exe_mem_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        RDSrc = 0, PCtoRegSrc = 0, MemtoReg = 0, MemWrite = 0, MemRead = 0, RegWrite = 0;
  logic [31:0] pc = '0, imm = '0, alu = '0, rs2 = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  f3 = '0;

  logic        o_rdsrc, o_m2r, o_mw, o_mr, o_rw, o_lp, o_ma;
  logic [31:0] o_pc2r, o_alu, o_rs2;
  logic [4:0]  o_rd;
  logic [2:0]  o_f3;
  logic [7:0]  o_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  exe_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .IDEXE_RDSrc(RDSrc), .IDEXE_PCtoRegSrc(PCtoRegSrc), .IDEXE_MemtoReg(MemtoReg),
    .IDEXE_MemWrite(MemWrite), .IDEXE_MemRead(MemRead), .IDEXE_RegWrite(RegWrite),
    .IDEXE_pc(pc), .IDEXE_imm(imm), .IDEXE_rd_addr(rd), .IDEXE_funct3(f3),
    .ALU_out(alu), .rs2_fwd_data(rs2),
    .EXEMEM_RDSrc(o_rdsrc), .EXEMEM_MemtoReg(o_m2r), .EXEMEM_MemWrite(o_mw),
    .EXEMEM_MemRead(o_mr), .EXEMEM_RegWrite(o_rw), .EXEMEM_pc_to_reg(o_pc2r),
    .EXEMEM_ALU_out(o_alu), .EXEMEM_rs2_data(o_rs2), .EXEMEM_rd_addr(o_rd),
    .EXEMEM_funct3(o_f3), .EXEMEM_load_pending(o_lp), .EXEMEM_misalign(o_ma),
    .ma_count(o_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RDSrc = 0; PCtoRegSrc = 0; MemtoReg = 0; MemWrite = 0; MemRead = 0; RegWrite = 0;
    pc = '0; imm = '0; alu = '0; rs2 = '0; rd = '0; f3 = '0;
    stall = 0; flush = 0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctrl"}, {27'd0, o_rdsrc, o_m2r, o_mw, o_mr, o_rw}, 32'd0);
    check({pfx, "_lp_ma"}, {30'd0, o_lp, o_ma}, 32'd0);
    check({pfx, "_pc2r"}, o_pc2r, 32'd0);
    check({pfx, "_alu"}, o_alu, 32'd0);
    check({pfx, "_rs2"}, o_rs2, 32'd0);
    check({pfx, "_rd_f3"}, {24'd0, o_rd, o_f3}, 32'd0);
    check({pfx, "_cnt"}, {24'd0, o_cnt}, 32'd0);
  endtask

  initial begin
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst = 0;

    // Aligned word load
    clear_inputs();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; f3 = 3'b010; alu = 32'h0000_1004; rd = 5'd5; pc = 32'h40;
    step();
    check("ld_memread", {31'd0, o_mr}, 32'd1);
    check("ld_pending", {31'd0, o_lp}, 32'd1);
    check("ld_misalign", {31'd0, o_ma}, 32'd0);
    check("ld_alu", o_alu, 32'h0000_1004);
    check("ld_rd", {27'd0, o_rd}, 32'd5);
    check("ld_pc2r", o_pc2r, 32'h44);

    // Misaligned halfword store
    clear_inputs();
    MemWrite = 1; RegWrite = 1; f3 = 3'b001; alu = 32'h0000_2003; rs2 = 32'hDEAD_BEEF; rd = 5'd9;
    step();
    check("st_misalign", {31'd0, o_ma}, 32'd1);
    check("st_memwrite", {31'd0, o_mw}, 32'd0);
    check("st_regwrite", {31'd0, o_rw}, 32'd0);
    check("st_rs2", o_rs2, 32'hDEAD_BEEF);
    check("st_cnt1", {24'd0, o_cnt}, 32'd1);
    for (int i = 0; i < 299; i++) step();
    check("st_cnt_sat", {24'd0, o_cnt}, 32'd255);

    // Asynchronous reset mid-cycle with every input nonzero
    RDSrc = 1; PCtoRegSrc = 1; MemtoReg = 1; MemRead = 1; MemWrite = 1; RegWrite = 1;
    pc = 32'h1234; imm = 32'h10; alu = 32'h5555_0001; rs2 = 32'h7777; rd = 5'd31; f3 = 3'b010;
    step();
    #2;
    rst = 1;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst = 0;

    // Byte load at an odd address is never misaligned
    clear_inputs();
    MemRead = 1; RegWrite = 1; f3 = 3'b100; alu = 32'h3; rd = 5'd3;
    step();
    check("lb_misalign", {31'd0, o_ma}, 32'd0);
    check("lb_memread", {31'd0, o_mr}, 32'd1);
    check("lb_cnt", {24'd0, o_cnt}, 32'd0);

    // Stall holds everything while inputs (including a misaligned access) change
    clear_inputs();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; f3 = 3'b010; alu = 32'h1000; rd = 5'd7; pc = 32'h200;
    step();
    stall = 1; MemRead = 0; MemWrite = 1; f3 = 3'b001; rd = 5'd9; pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      alu = 32'h2001 + 32'(i * 2);
      step();
      check("stl_alu", o_alu, 32'h1000);
      check("stl_rd_mr", {26'd0, o_rd, o_mr}, {26'd0, 5'd7, 1'b1});
      check("stl_cnt", {24'd0, o_cnt}, 32'd0);
    end
    check("stl_pc2r", o_pc2r, 32'h204);
    flush = 1;
    step();
    check("fl_ctrl", {27'd0, o_rdsrc, o_m2r, o_mw, o_mr, o_rw}, 32'd0);
    check("fl_lp_ma", {30'd0, o_lp, o_ma}, 32'd0);
    check("fl_alu", o_alu, 32'd0);
    check("fl_cnt", {24'd0, o_cnt}, 32'd0);

    // pc_to_reg arithmetic with wrap
    clear_inputs();
    pc = 32'hFFFF_FFFC; PCtoRegSrc = 0;
    step();
    check("pc4_wrap", o_pc2r, 32'h0000_0000);
    pc = 32'h100; imm = 32'hFFFF_FFF0; PCtoRegSrc = 1; RDSrc = 1;
    step();
    check("pcimm_neg", o_pc2r, 32'h0000_00F0);
    check("pcimm_rdsrc", {31'd0, o_rdsrc}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
